// File: rtl/guitar_pkg.sv
// Shared guitar-game definitions: note width, judge FSM states and default
// scoring parameters. Used by the notes register, note_judge and the display.
package guitar_pkg;

  localparam int unsigned NOTE_W              = 5;
  localparam int unsigned DEFAULT_NOTE_POINTS = 10;
  localparam int unsigned DEFAULT_STREAK_STEP = 10;
  localparam int unsigned DEFAULT_MAX_MULT    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no chord pending
    ARMED  = 2'd1,  // chord latched, awaiting strum
    JUDGED = 2'd2   // window already scored
  } judge_state_t;

endpackage

// File: rtl/strum_edge.sv
// Strum conditioning: two-flop synchroniser followed by a rising-edge
// detector. strum_p is a registered one-cycle pulse per press.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high
//   strum   in  raw asynchronous strum button level
//   strum_p out one-cycle pulse on each synchronised rising edge
module strum_edge (
  input  logic clk,
  input  logic reset,
  input  logic strum,
  output logic strum_p
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  // Runs regardless of pause so a held button never looks like a new press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
      strum_p   <= 1'b0;
    end else begin
      sync_1    <= strum;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      strum_p   <= sync_2 & ~sync_prev;
    end
  end

endmodule

// File: rtl/note_judge.sv
// Note judge: opens one judgement window per beat, scores the player's frets
// on a strum edge and keeps score, streak and multiplier.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   beat                   one-cycle pulse opening a new window
//   pause, stop            levels; stop has priority and clears the window
//   notes_to_play [4:0]    chord latched on beat
//   frets [4:0]            player fret buttons (synchronous)
//   strum                  raw asynchronous strum button
//   correct_notes [4:0]    chord of the current window once hit, else 0
//   hit, miss              one-cycle judgement pulses
//   score [SCORE_W-1:0]    saturating accumulated points
//   streak [7:0]           consecutive hits, saturating
//   multiplier [2:0]       1..MAX_MULT, lags streak by one cycle
module note_judge
  import guitar_pkg::*;
#(
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned NOTE_POINTS = DEFAULT_NOTE_POINTS,
  parameter int unsigned STREAK_STEP = DEFAULT_STREAK_STEP,
  parameter int unsigned MAX_MULT    = DEFAULT_MAX_MULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               beat,
  input  logic               pause,
  input  logic               stop,
  input  logic [4:0]         notes_to_play,
  input  logic [4:0]         frets,
  input  logic               strum,
  output logic [4:0]         correct_notes,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         streak,
  output logic [2:0]         multiplier
);

  localparam int unsigned SUM_W = SCORE_W + 3;

  judge_state_t      state;
  logic [NOTE_W-1:0] exp_notes;
  logic              strum_p;
  logic              strum_pend;   // strum deferred by a coincident beat

  logic              strum_go_c;
  logic [8:0]        mult_raw_c;
  logic [2:0]        mult_next_c;
  logic [SUM_W-1:0]  sum_c;
  logic [SCORE_W-1:0] score_hit_c;
  logic [7:0]        streak_inc_c;

  strum_edge u_strum_edge (
    .clk     (clk),
    .reset   (reset),
    .strum   (strum),
    .strum_p (strum_p)
  );

  assign strum_go_c = strum_p | strum_pend;

  // Multiplier target from the registered streak, capped at MAX_MULT.
  assign mult_raw_c  = 9'(streak / 8'(STREAK_STEP)) + 9'd1;
  assign mult_next_c = (mult_raw_c > 9'(MAX_MULT)) ? 3'(MAX_MULT) : 3'(mult_raw_c);

  // Score update uses the multiplier in effect before this hit, saturating.
  assign sum_c       = SUM_W'(score) + SUM_W'(NOTE_POINTS) * SUM_W'(multiplier);
  assign score_hit_c = (sum_c > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}}
                                                         : sum_c[SCORE_W-1:0];
  assign streak_inc_c = (streak == 8'hFF) ? 8'hFF : streak + 8'd1;

  // Judge FSM with score/streak datapath and multiplier register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      exp_notes     <= '0;
      strum_pend    <= 1'b0;
      correct_notes <= '0;
      hit           <= 1'b0;
      miss          <= 1'b0;
      score         <= '0;
      streak        <= '0;
      multiplier    <= 3'd1;
    end else begin
      hit        <= 1'b0;
      miss       <= 1'b0;
      multiplier <= mult_next_c;
      if (stop) begin
        state         <= IDLE;
        exp_notes     <= '0;
        correct_notes <= '0;
        strum_pend    <= 1'b0;
      end else if (!pause) begin
        if (beat) begin
          // Beat wins; any strum this cycle is judged against the new window.
          if (state == ARMED) begin
            miss   <= 1'b1;
            streak <= '0;
          end
          exp_notes     <= notes_to_play;
          correct_notes <= '0;
          state         <= (notes_to_play != '0) ? ARMED : IDLE;
          strum_pend    <= strum_go_c;
        end else begin
          strum_pend <= 1'b0;
          if (strum_go_c) begin
            if (state == ARMED) begin
              if (frets == exp_notes) begin
                hit           <= 1'b1;
                correct_notes <= exp_notes;
                score         <= score_hit_c;
                streak        <= streak_inc_c;
              end else begin
                miss   <= 1'b1;
                streak <= '0;
              end
              state <= JUDGED;
            end else begin
              miss   <= 1'b1;
              streak <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_note_judge.sv
module tb_note_judge;

  logic        clk = 1'b0;
  logic        reset;
  logic        beat;
  logic        pause;
  logic        stop;
  logic [4:0]  notes_to_play;
  logic [4:0]  frets;
  logic        strum;
  logic [4:0]  correct_notes;
  logic        hit;
  logic        miss;
  logic [15:0] score;
  logic [7:0]  streak;
  logic [2:0]  multiplier;

  int total = 0;
  int bad   = 0;

  note_judge dut (
    .clk           (clk),
    .reset         (reset),
    .beat          (beat),
    .pause         (pause),
    .stop          (stop),
    .notes_to_play (notes_to_play),
    .frets         (frets),
    .strum         (strum),
    .correct_notes (correct_notes),
    .hit           (hit),
    .miss          (miss),
    .score         (score),
    .streak        (streak),
    .multiplier    (multiplier)
  );

  always #5 clk = ~clk;

  // Stimulus helpers; all return 1ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_beat(input logic [4:0] chord);
    beat = 1'b1; notes_to_play = chord;
    tick(1);
    beat = 1'b0;
  endtask

  // Press strum and return when the judgement is visible.
  task automatic press_strum();
    strum = 1'b1;
    tick(4);
  endtask

  task automatic release_strum();
    strum = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic do_hit(input logic [4:0] chord);
    frets = chord;
    pulse_beat(chord);
    press_strum();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (score !== 16'd0) begin bad++; $display("FAIL reset_score: got %0d want 0", score); end
    total++; if (streak !== 8'd0) begin bad++; $display("FAIL reset_streak: got %0d want 0", streak); end
    total++; if (multiplier !== 3'd1) begin bad++; $display("FAIL reset_mult: got %0d want 1", multiplier); end
    total++; if ({hit, miss, correct_notes} !== 7'd0) begin bad++; $display("FAIL reset_outs: got hit=%b miss=%b cn=%b want 0", hit, miss, correct_notes); end
  endtask

  task automatic test_hit();
    do_hit(5'b00101);
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL hit_pulse: got %b want 1", hit); end
    total++; if (correct_notes !== 5'b00101) begin bad++; $display("FAIL hit_cn: got %b want 00101", correct_notes); end
    total++; if (score !== 16'd10) begin bad++; $display("FAIL hit_score: got %0d want 10", score); end
    total++; if (streak !== 8'd1) begin bad++; $display("FAIL hit_streak: got %0d want 1", streak); end
    total++; if (multiplier !== 3'd1) begin bad++; $display("FAIL hit_mult: got %0d want 1", multiplier); end
    tick(1);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL hit_one_cycle: got %b want 0", hit); end
    total++; if (multiplier !== 3'd1) begin bad++; $display("FAIL hit_mult_after: got %0d want 1", multiplier); end
    release_strum();
  endtask

  task automatic test_wrong_then_overstrum();
    frets = 5'b01000;
    pulse_beat(5'b10000);
    press_strum();
    total++; if ({hit, miss} !== 2'b01) begin bad++; $display("FAIL wrong_pulse: got hit=%b miss=%b want 0/1", hit, miss); end
    total++; if (streak !== 8'd0) begin bad++; $display("FAIL wrong_streak: got %0d want 0", streak); end
    total++; if (score !== 16'd10) begin bad++; $display("FAIL wrong_score: got %0d want 10", score); end
    release_strum();
    press_strum();
    total++; if ({hit, miss} !== 2'b01) begin bad++; $display("FAIL overstrum_pulse: got hit=%b miss=%b want 0/1", hit, miss); end
    total++; if (score !== 16'd10) begin bad++; $display("FAIL overstrum_score: got %0d want 10", score); end
    release_strum();
    // From JUDGED a new beat carries no miss.
    pulse_beat(5'b00000);
    total++; if (miss !== 1'b0) begin bad++; $display("FAIL judged_beat_miss: got %b want 0", miss); end
  endtask

  task automatic test_multiplier();
    do_reset();
    for (int i = 1; i <= 41; i++) begin
      do_hit(5'b00001);
      if (i == 10) begin
        total++; if (streak !== 8'd10) begin bad++; $display("FAIL mult_streak10: got %0d want 10", streak); end
        total++; if (score !== 16'd100) begin bad++; $display("FAIL mult_score10: got %0d want 100", score); end
        total++; if (multiplier !== 3'd1) begin bad++; $display("FAIL mult_lag: got %0d want 1", multiplier); end
        tick(1);
        total++; if (multiplier !== 3'd2) begin bad++; $display("FAIL mult_step2: got %0d want 2", multiplier); end
      end
      if (i == 11) begin
        total++; if (score !== 16'd120) begin bad++; $display("FAIL mult_score11: got %0d want 120", score); end
      end
      if (i == 30) begin
        total++; if (score !== 16'd600) begin bad++; $display("FAIL mult_score30: got %0d want 600", score); end
        tick(1);
        total++; if (multiplier !== 3'd4) begin bad++; $display("FAIL mult_step4: got %0d want 4", multiplier); end
      end
      release_strum();
    end
    total++; if (score !== 16'd1040) begin bad++; $display("FAIL mult_score41: got %0d want 1040", score); end
    total++; if (multiplier !== 3'd4) begin bad++; $display("FAIL mult_cap: got %0d want 4", multiplier); end
  endtask

  task automatic test_missed_chord();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_hit(5'b00010);
      release_strum();
    end
    total++; if (streak !== 8'd5) begin bad++; $display("FAIL missed_pre_streak: got %0d want 5", streak); end
    pulse_beat(5'b00011);
    tick(3);
    pulse_beat(5'b00000);
    total++; if (miss !== 1'b1) begin bad++; $display("FAIL missed_pulse: got %b want 1", miss); end
    total++; if (streak !== 8'd0) begin bad++; $display("FAIL missed_streak: got %0d want 0", streak); end
    tick(1);
    total++; if (miss !== 1'b0) begin bad++; $display("FAIL missed_one_cycle: got %b want 0", miss); end
    pulse_beat(5'b00000);
    total++; if (miss !== 1'b0) begin bad++; $display("FAIL empty_window_miss: got %b want 0", miss); end
  endtask

  task automatic test_coincident();
    do_reset();
    frets = 5'b11000;
    pulse_beat(5'b00110);
    strum = 1'b1;
    tick(3);                 // strum_p is now high for the coming edge
    beat = 1'b1; notes_to_play = 5'b11000;
    tick(1);
    beat = 1'b0;
    total++; if ({hit, miss} !== 2'b01) begin bad++; $display("FAIL coinc_miss: got hit=%b miss=%b want 0/1", hit, miss); end
    tick(1);
    total++; if ({hit, miss} !== 2'b10) begin bad++; $display("FAIL coinc_hit: got hit=%b miss=%b want 1/0", hit, miss); end
    total++; if (correct_notes !== 5'b11000) begin bad++; $display("FAIL coinc_cn: got %b want 11000", correct_notes); end
    total++; if (score !== 16'd10) begin bad++; $display("FAIL coinc_score: got %0d want 10", score); end
    release_strum();
  endtask

  task automatic test_pause();
    logic seen;
    do_reset();
    frets = 5'b00101;
    pulse_beat(5'b00101);
    pause = 1'b1;
    pulse_beat(5'b11111);    // lost, and no miss for the armed window
    total++; if (miss !== 1'b0) begin bad++; $display("FAIL pause_beat_miss: got %b want 0", miss); end
    strum = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(1); seen = seen | hit | miss; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL pause_strum_pulse: got %b want 0", seen); end
    total++; if (score !== 16'd0) begin bad++; $display("FAIL pause_score: got %0d want 0", score); end
    pause = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(1); seen = seen | hit | miss; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL unpause_edge: got %b want 0", seen); end
    release_strum();
    press_strum();
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL pause_old_window_hit: got %b want 1", hit); end
    total++; if (correct_notes !== 5'b00101) begin bad++; $display("FAIL pause_cn: got %b want 00101", correct_notes); end
    release_strum();
  endtask

  task automatic test_stop();
    stop = 1'b1;
    tick(1);
    total++; if (correct_notes !== 5'b00000) begin bad++; $display("FAIL stop_cn: got %b want 0", correct_notes); end
    total++; if (score !== 16'd10) begin bad++; $display("FAIL stop_score: got %0d want 10", score); end
    total++; if (streak !== 8'd1) begin bad++; $display("FAIL stop_streak: got %0d want 1", streak); end
    pulse_beat(5'b00101);
    press_strum();
    total++; if ({hit, miss} !== 2'b00) begin bad++; $display("FAIL stop_ignored: got hit=%b miss=%b want 0/0", hit, miss); end
    release_strum();
    stop = 1'b0;
    tick(1);
    press_strum();
    total++; if ({hit, miss} !== 2'b01) begin bad++; $display("FAIL after_stop_idle: got hit=%b miss=%b want 0/1", hit, miss); end
    total++; if (score !== 16'd10) begin bad++; $display("FAIL after_stop_score: got %0d want 10", score); end
    release_strum();
  endtask

  task automatic test_reset_armed();
    do_hit(5'b00101);
    release_strum();
    pulse_beat(5'b00111);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    total++; if (score !== 16'd0) begin bad++; $display("FAIL rst_armed_score: got %0d want 0", score); end
    total++; if (streak !== 8'd0) begin bad++; $display("FAIL rst_armed_streak: got %0d want 0", streak); end
    total++; if (multiplier !== 3'd1) begin bad++; $display("FAIL rst_armed_mult: got %0d want 1", multiplier); end
    total++; if ({hit, miss, correct_notes} !== 7'd0) begin bad++; $display("FAIL rst_armed_outs: got hit=%b miss=%b cn=%b want 0", hit, miss, correct_notes); end
    pulse_beat(5'b00000);
    total++; if (miss !== 1'b0) begin bad++; $display("FAIL rst_window_discard: got %b want 0", miss); end
  endtask

  initial begin
    reset = 1'b1; beat = 1'b0; pause = 1'b0; stop = 1'b0;
    notes_to_play = '0; frets = '0; strum = 1'b0;
    test_reset();
    test_hit();
    test_wrong_then_overstrum();
    test_multiplier();
    test_missed_chord();
    test_coincident();
    test_pause();
    test_stop();
    test_reset_armed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
